// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised FIFO.
//   fifo_mode_e : read-port behaviour (registered read or first-word-fall-through)
//   ptr_w()     : address width for a given entry count (at least 1 bit)
package fifo_pkg;

    typedef enum logic {
        MODE_REG  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for param_fifo: simple dual-port, synchronous write,
// asynchronous (combinational) read. Contents are not reset.
//   clk_in  : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data for i_raddr, same cycle
module fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AW         = 3
) (
    input  logic                  clk_in,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with arbitrary depth, selectable read mode, almost-full /
// almost-empty thresholds, sticky overflow/underflow flags and flush.
//   clk_in / rst_in        : clock, synchronous active-high reset
//   flush_in               : discard contents, clear flags (data_out holds)
//   enq_in / enq_data_in   : enqueue request and data
//   deq_in                 : dequeue request (pop in FWFT mode)
//   data_out / valid_out   : read data and qualifier
//   full_out / empty_out   : occupancy == DEPTH / == 0
//   almost_full_out        : occupancy >= AF_THRESH
//   almost_empty_out       : occupancy <= AE_THRESH
//   count_out              : current occupancy
//   overflow_out / underflow_out : sticky rejected-request flags
module param_fifo
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         DEPTH      = 8,
    parameter fifo_mode_e MODE       = MODE_REG,
    parameter int         AF_THRESH  = DEPTH - 1,
    parameter int         AE_THRESH  = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       flush_in,
    input  logic                       enq_in,
    input  logic [DATA_WIDTH-1:0]      enq_data_in,
    input  logic                       deq_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       valid_out,
    output logic                       full_out,
    output logic                       empty_out,
    output logic                       almost_full_out,
    output logic                       almost_empty_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       overflow_out,
    output logic                       underflow_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = ptr_w(DEPTH);
    localparam logic [AW-1:0] LP_LAST = AW'(DEPTH - 1);

    if (DEPTH < 2 || AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_params
        $error("param_fifo: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_ovf;
    logic                  r_unf;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_enq_acc;
    logic                  w_deq_acc;
    logic [DATA_WIDTH-1:0] w_head;

    // Pointers wrap explicitly since DEPTH need not be a power of two.
    function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
        return (p == LP_LAST) ? '0 : p + 1'b1;
    endfunction

    // All status flags come from the count register only.
    assign w_full           = (r_count == CW'(DEPTH));
    assign w_empty          = (r_count == '0);
    assign full_out         = w_full;
    assign empty_out        = w_empty;
    assign almost_full_out  = (r_count >= CW'(AF_THRESH));
    assign almost_empty_out = (r_count <= CW'(AE_THRESH));
    assign count_out        = r_count;
    assign overflow_out     = r_ovf;
    assign underflow_out    = r_unf;

    // Acceptance uses only the pre-edge full/empty state: no pass-through
    // when full, no bypass when empty. Reset and flush suppress both.
    assign w_enq_acc = enq_in && !w_full  && !flush_in && !rst_in;
    assign w_deq_acc = deq_in && !w_empty && !flush_in && !rst_in;

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk_in  (clk_in),
        .i_we    (w_enq_acc),
        .i_waddr (r_wptr),
        .i_wdata (enq_data_in),
        .i_raddr (r_rptr),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_enq_acc) r_wptr <= f_next(r_wptr);
            if (w_deq_acc) r_rptr <= f_next(r_rptr);
            case ({w_enq_acc, w_deq_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (enq_in && w_full)  r_ovf <= 1'b1;
            if (deq_in && w_empty) r_unf <= 1'b1;
        end
    end

    if (MODE == MODE_REG) begin : g_reg
        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_valid;

        // One-cycle valid pulse per accepted dequeue; data holds otherwise,
        // including across flush.
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (flush_in) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_deq_acc;
                if (w_deq_acc) r_data <= w_head;
            end
        end

        assign data_out  = r_data;
        assign valid_out = r_valid;
    end else begin : g_fwft
        assign data_out  = w_head;
        assign valid_out = !w_empty;
    end

endmodule
